// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle HI/LO multiply, accumulate and restoring divide unit for the EX stage.
module ex_muldiv #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              annul,
  output logic              stall_req,
  output logic              done,
  output logic              whilo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_by_zero
);
  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W + MUL_STAGES + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0]     op_r;
  logic [2*W-1:0] acc;
  logic [W-1:0]   a_mag, b_mag, quo, rem, m1, m2;
  logic           neg_a, neg_p, dbz, sgn, is_div, zero_div, accept, valid;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] pipe [MUL_STAGES];
  logic [W:0]     rem_sh, trial;
  logic [2*W-1:0] prod_mag, prod, mul_res, res;
  always_comb begin
    sgn       = !op[0];
    is_div    = op[2:1] == 2'b01;
    zero_div  = src2 == '0;
    accept    = state == IDLE && start && !annul;
    m1        = (sgn && src1[W-1]) ? -src1 : src1;
    m2        = (sgn && src2[W-1]) ? -src2 : src2;
    rem_sh    = {rem, quo[W-1]};
    trial     = rem_sh - {1'b0, b_mag};
    prod_mag  = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
    prod      = neg_p ? -prod_mag : prod_mag;
    mul_res   = op_r[1] ? (op_r[0] ? acc - pipe[MUL_STAGES-1] : acc + pipe[MUL_STAGES-1]) : pipe[MUL_STAGES-1];
    res       = dbz ? '0 : (op_r == 2'b01 ? {neg_a ? -rem : rem, neg_p ? -quo : quo} : mul_res);
    valid     = state == DONE && !annul;
    done      = valid;
    whilo_out = valid && !dbz;
    div_by_zero = valid && dbz;
    {hi_out, lo_out} = valid ? res : '0;
    stall_req = state == MUL || state == DIV || accept;
  end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = !accept ? IDLE : !is_div ? MUL : zero_div ? DONE : DIV;
      MUL:     state_nxt = annul ? IDLE : cnt == CW'(MUL_STAGES - 1) ? DONE : MUL;
      DIV:     state_nxt = annul ? IDLE : cnt == CW'(W - 1) ? DONE : DIV;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // Multiplier stages free-run on the captured operands; only DONE reads the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= '0;
      acc   <= '0;
      a_mag <= '0;
      b_mag <= '0;
      quo   <= '0;
      rem   <= '0;
      neg_a <= 1'b0;
      neg_p <= 1'b0;
      dbz   <= 1'b0;
      cnt   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
    end else begin
      cnt     <= (state == MUL || state == DIV) ? cnt + 1'b1 : '0;
      pipe[0] <= prod;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
      if (accept) begin
        op_r  <= op[2:1];
        acc   <= {hi_in, lo_in};
        a_mag <= m1;
        b_mag <= m2;
        quo   <= m1;
        rem   <= '0;
        neg_a <= sgn && src1[W-1];
        neg_p <= (sgn && src1[W-1]) ^ (sgn && src2[W-1]);
        dbz   <= is_div && zero_div;
      end else if (state == DIV) begin
        rem <= trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
        quo <= {quo[W-2:0], !trial[W]};
      end
    end
  end
endmodule
